ahbl_master_arbiter: RTL

- Two-master AHB-Lite arbiter in front of the SoC address splitter.
- M0 is the Hazard2 CPU. M1 is a bus master such as a DMA or TinyML accelerator.
- Exactly one master owns the address phase at a time. The losing master is stalled via its private HREADY.
- Data-phase ownership is tracked so HWDATA is routed correctly and HRDATA and HREADY are returned to the right master.

---
 rtl/ahbl_master_arbiter.sv | 75 +++++++
 1 files changed

// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter: two-master AHB-Lite arbiter with data-phase routing and stall counter.
// Define ARB_PARK_M0_EN to park the grant back on M0 whenever both masters are idle.
module ahbl_master_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      M0_HADDR,
    input  logic [1:0]       M0_HTRANS,
    input  logic [2:0]       M0_HSIZE,
    input  logic             M0_HWRITE,
    input  logic [31:0]      M0_HWDATA,
    output logic             M0_HREADY,
    output logic [31:0]      M0_HRDATA,
    input  logic [31:0]      M1_HADDR,
    input  logic [1:0]       M1_HTRANS,
    input  logic [2:0]       M1_HSIZE,
    input  logic             M1_HWRITE,
    input  logic [31:0]      M1_HWDATA,
    output logic             M1_HREADY,
    output logic [31:0]      M1_HRDATA,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    output logic             ARB_OWNER,
    output logic [CNT_W-1:0] ARB_STALL_CNT,
    input  logic             ARB_CNT_CLR
);
    logic             addr_owner, data_owner;
    logic [CNT_W-1:0] stall_cnt;
    logic             own_req, other_req, switch_en, park_en;

    always_comb begin
        own_req   = addr_owner ? M1_HTRANS[1] : M0_HTRANS[1];
        other_req = addr_owner ? M0_HTRANS[1] : M1_HTRANS[1];
        // only hand over once the owner's IDLE is accepted, so it has no pending data phase
        switch_en = HREADY && !own_req && other_req;
`ifdef ARB_PARK_M0_EN
        park_en   = HREADY && addr_owner && !M0_HTRANS[1] && !M1_HTRANS[1];
`else
        park_en   = 1'b0;
`endif
    end

    assign HADDR         = addr_owner ? M1_HADDR  : M0_HADDR;
    assign HTRANS        = addr_owner ? M1_HTRANS : M0_HTRANS;
    assign HSIZE         = addr_owner ? M1_HSIZE  : M0_HSIZE;
    assign HWRITE        = addr_owner ? M1_HWRITE : M0_HWRITE;
    assign HWDATA        = data_owner ? M1_HWDATA : M0_HWDATA;
    assign M0_HREADY     = addr_owner ? !M0_HTRANS[1] : HREADY;
    assign M1_HREADY     = addr_owner ? HREADY : !M1_HTRANS[1];
    assign M0_HRDATA     = HRDATA;
    assign M1_HRDATA     = HRDATA;
    assign ARB_OWNER     = addr_owner;
    assign ARB_STALL_CNT = stall_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner <= 1'b0;
            data_owner <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (HREADY) data_owner <= addr_owner;
            if (switch_en) addr_owner <= !addr_owner;
            else if (park_en) addr_owner <= 1'b0;
            // wait states freeze the counter along with the rest of the arbiter state
            if (ARB_CNT_CLR) stall_cnt <= '0;
            else if (HREADY && other_req && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
